risc_toy_fetch: RTL and testbench



---
 rtl/risc_toy_pkg.sv | 29 ++
 rtl/risc_toy_pc.sv | 56 +++++
 rtl/risc_toy_fetch.sv | 82 ++++++++
 tb/tb_risc_toy_fetch.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_toy_pkg.sv
// Shared constants for the RISC_TOY core: datapath widths, instruction field
// positions, the fetch-stage state encoding and the opcodes the decoder uses.
package risc_toy_pkg;

    localparam int IF_AW = 30;
    localparam int IF_DW = 32;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 22;
    localparam int RB_MSB = 21;
    localparam int RB_LSB = 17;
    localparam int RC_MSB = 16;
    localparam int RC_LSB = 12;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_BR  = 5'b01111;
    localparam opcode_t OP_BRL = 5'b10000;
    localparam opcode_t OP_J   = 5'b10001;
    localparam opcode_t OP_JL  = 5'b10010;

endpackage

// File: rtl/risc_toy_pc.sv
// Program counter with the BOOT/RUN sequencer and next-PC selection
// (redirect over stall over sequential increment).
module risc_toy_pc
    import risc_toy_pkg::*;
#(
    parameter int             AW       = IF_AW,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_stall,
    input  logic          i_redir_valid,
    input  logic [AW-1:0] i_redir_addr,
    output logic          o_run,
    output logic          o_advance,
    output logic          o_squash,
    output logic [AW-1:0] o_pc
);

    fetch_state_e  r_state;
    fetch_state_e  w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // BOOT ignores stall and redirect so memory gets one idle cycle to settle.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (i_redir_valid) begin
                    w_pc_nxt = i_redir_addr;
                end else if (!i_stall) begin
                    w_pc_nxt = r_pc + AW'(1);
                end
            end
        endcase
    end

    assign o_run     = (r_state == ST_RUN);
    assign o_squash  = o_run & i_redir_valid;
    assign o_advance = o_run & ~i_redir_valid & ~i_stall;
    assign o_pc      = r_pc;

endmodule

// File: rtl/risc_toy_fetch.sv
// Instruction-fetch stage: drives the instruction memory from the PC and
// holds the IF/ID register with pre-split fields and the link value.
module risc_toy_fetch
    import risc_toy_pkg::*;
#(
    parameter int            AW       = IF_AW,
    parameter int            DW       = IF_DW,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          CLK,
    input  logic          RSTN,
    output logic          IREQ,
    output logic [AW-1:0] IADDR,
    input  logic [DW-1:0] INSTR,
    input  logic          stall_i,
    input  logic          redir_valid_i,
    input  logic [AW-1:0] redir_addr_i,
    output logic          fi_valid,
    output logic [DW-1:0] fi_instr,
    output logic [4:0]    fi_op,
    output logic [4:0]    fi_ra,
    output logic [4:0]    fi_rb,
    output logic [4:0]    fi_rc,
    output logic [AW-1:0] fi_iaddr,
    output logic [DW-1:0] fi_link
);

    logic          w_run;
    logic          w_advance;
    logic          w_squash;
    logic [AW-1:0] w_pc;
    logic [AW-1:0] w_next_iaddr;

    logic          r_valid;
    logic [DW-1:0] r_instr;
    logic [AW-1:0] r_iaddr;

    risc_toy_pc #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .i_clk         (CLK),
        .i_rst_n       (RSTN),
        .i_stall       (stall_i),
        .i_redir_valid (redir_valid_i),
        .i_redir_addr  (redir_addr_i),
        .o_run         (w_run),
        .o_advance     (w_advance),
        .o_squash      (w_squash),
        .o_pc          (w_pc)
    );

    // A squash only clears the valid tag; the stale instruction stays behind.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_iaddr <= '0;
        end else if (w_squash) begin
            r_valid <= 1'b0;
        end else if (w_advance) begin
            r_valid <= 1'b1;
            r_instr <= INSTR;
            r_iaddr <= w_pc;
        end
    end

    assign IREQ  = w_run;
    assign IADDR = w_pc;

    assign w_next_iaddr = r_iaddr + AW'(1);

    assign fi_valid = r_valid;
    assign fi_instr = r_instr;
    assign fi_iaddr = r_iaddr;
    assign fi_op    = r_instr[OP_MSB:OP_LSB];
    assign fi_ra    = r_instr[RA_MSB:RA_LSB];
    assign fi_rb    = r_instr[RB_MSB:RB_LSB];
    assign fi_rc    = r_instr[RC_MSB:RC_LSB];
    assign fi_link  = {w_next_iaddr, 2'b00};

endmodule

// File: tb/tb_risc_toy_fetch.sv
// Scoreboard bench for risc_toy_fetch: directed scenarios followed by random
// stall/redirect/reset traffic against a behavioural fetch model.
module tb_risc_toy_fetch;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        IREQ;
    logic [29:0] IADDR;
    logic [31:0] INSTR;
    logic        stall_i = 1'b0;
    logic        redir_valid_i = 1'b0;
    logic [29:0] redir_addr_i = '0;
    logic        fi_valid;
    logic [31:0] fi_instr;
    logic [4:0]  fi_op;
    logic [4:0]  fi_ra;
    logic [4:0]  fi_rb;
    logic [4:0]  fi_rc;
    logic [29:0] fi_iaddr;
    logic [31:0] fi_link;

    logic        mem_mode = 1'b0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        ireq;
        logic [29:0] iaddr;
        logic        v;
        logic [31:0] instr;
        logic [29:0] fia;
    } exp_t;

    exp_t sb[$];

    // Behavioural model state: what the fetch stage should hold after each edge.
    logic        m_run = 1'b0;
    logic [29:0] m_pc = '0;
    logic        m_v = 1'b0;
    logic [31:0] m_instr = '0;
    logic [29:0] m_fia = '0;

    risc_toy_fetch dut (
        .CLK           (CLK),
        .RSTN          (RSTN),
        .IREQ          (IREQ),
        .IADDR         (IADDR),
        .INSTR         (INSTR),
        .stall_i       (stall_i),
        .redir_valid_i (redir_valid_i),
        .redir_addr_i  (redir_addr_i),
        .fi_valid      (fi_valid),
        .fi_instr      (fi_instr),
        .fi_op         (fi_op),
        .fi_ra         (fi_ra),
        .fi_rb         (fi_rb),
        .fi_rc         (fi_rc),
        .fi_iaddr      (fi_iaddr),
        .fi_link       (fi_link)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_fn(input logic [29:0] a, input logic mode);
        if (!mode) return {2'b00, a} | 32'hA000_0000;
        return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    assign INSTR = mem_fn(IADDR, mem_mode);

    function automatic logic [31:0] link_of(input logic [29:0] a);
        logic [32:0] t;
        t = (33'(a) + 33'd1) * 33'd4;
        return t[31:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic model_edge(input logic st, input logic rd, input logic [29:0] ra);
        exp_t e;
        if (!m_run) begin
            m_run = 1'b1;
        end else if (rd) begin
            m_pc = ra;
            m_v  = 1'b0;
        end else if (!st) begin
            m_instr = mem_fn(m_pc, mem_mode);
            m_fia   = m_pc;
            m_v     = 1'b1;
            m_pc    = m_pc + 30'd1;
        end
        e.ireq  = m_run;
        e.iaddr = m_pc;
        e.v     = m_v;
        e.instr = m_instr;
        e.fia   = m_fia;
        sb.push_back(e);
    endtask

    task automatic step(input logic st, input logic rd, input logic [29:0] ra);
        @(negedge CLK);
        stall_i       = st;
        redir_valid_i = rd;
        redir_addr_i  = ra;
        model_edge(st, rd, ra);
        @(posedge CLK);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ireq"}, 32'(IREQ), 32'h0);
        chk({tag, "_iaddr"}, 32'(IADDR), 32'h0);
        chk({tag, "_fi_valid"}, 32'(fi_valid), 32'h0);
        chk({tag, "_fi_instr"}, fi_instr, 32'h0);
        chk({tag, "_fi_iaddr"}, 32'(fi_iaddr), 32'h0);
        chk({tag, "_fi_op"}, 32'(fi_op), 32'h0);
        chk({tag, "_fi_link"}, fi_link, 32'h4);
    endtask

    // Reset pulse placed between edges; inputs applied at release must be ignored in BOOT.
    task automatic reset_pulse(input logic st, input logic rd, input logic [29:0] ra);
        @(negedge CLK);
        RSTN = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        m_run = 1'b0; m_pc = '0; m_v = 1'b0; m_instr = '0; m_fia = '0;
        #1;
        RSTN          = 1'b1;
        stall_i       = st;
        redir_valid_i = rd;
        redir_addr_i  = ra;
        model_edge(st, rd, ra);
        @(posedge CLK);
        #2;
    endtask

    // Monitor: every clocked cycle with a pending expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_ireq", 32'(IREQ), 32'(e.ireq));
                chk("sb_iaddr", 32'(IADDR), 32'(e.iaddr));
                chk("sb_fi_valid", 32'(fi_valid), 32'(e.v));
                chk("sb_fi_instr", fi_instr, e.instr);
                chk("sb_fi_iaddr", 32'(fi_iaddr), 32'(e.fia));
                chk("sb_fi_op", 32'(fi_op), (e.instr >> 27) & 32'h1F);
                chk("sb_fi_ra", 32'(fi_ra), (e.instr >> 22) & 32'h1F);
                chk("sb_fi_rb", 32'(fi_rb), (e.instr >> 17) & 32'h1F);
                chk("sb_fi_rc", 32'(fi_rc), (e.instr >> 12) & 32'h1F);
                chk("sb_fi_link", fi_link, link_of(e.fia));
            end
        end
    end

    initial begin
        logic [29:0] addr;
        int          r;

        // Reset held: all outputs at reset values.
        @(negedge CLK);
        #1;
        check_reset_outputs("reset_hold");

        // Release, BOOT edge, then sequential fetch.
        @(negedge CLK);
        RSTN = 1'b1;
        model_edge(1'b0, 1'b0, '0);
        @(posedge CLK);
        #2;
        chk("boot_ireq", 32'(IREQ), 32'h1);
        chk("boot_iaddr", 32'(IADDR), 32'h0);
        chk("boot_fi_valid", 32'(fi_valid), 32'h0);
        step(1'b0, 1'b0, '0);
        chk("first_fi_valid", 32'(fi_valid), 32'h1);
        chk("first_fi_iaddr", 32'(fi_iaddr), 32'h0);
        chk("first_fi_instr", fi_instr, 32'hA000_0000);
        chk("first_fi_link", fi_link, 32'h4);
        chk("first_iaddr", 32'(IADDR), 32'h1);

        // Stall for three cycles at IADDR=5.
        while (m_pc != 30'd5) step(1'b0, 1'b0, '0);
        repeat (3) begin
            step(1'b1, 1'b0, '0);
            chk("stall_iaddr", 32'(IADDR), 32'h5);
            chk("stall_fi_iaddr", 32'(fi_iaddr), 32'h4);
            chk("stall_fi_valid", 32'(fi_valid), 32'h1);
        end
        step(1'b0, 1'b0, '0);
        chk("unstall_fi_iaddr", 32'(fi_iaddr), 32'h5);

        // Redirect at PC=8.
        while (m_pc != 30'd8) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 30'h100);
        chk("redir_iaddr", 32'(IADDR), 32'h100);
        chk("redir_bubble", 32'(fi_valid), 32'h0);
        step(1'b0, 1'b0, '0);
        chk("redir_fi_valid", 32'(fi_valid), 32'h1);
        chk("redir_fi_iaddr", 32'(fi_iaddr), 32'h100);

        // Redirect and stall together: redirect wins.
        step(1'b1, 1'b1, 30'h40);
        chk("redir_stall_iaddr", 32'(IADDR), 32'h40);
        chk("redir_stall_fi_valid", 32'(fi_valid), 32'h0);
        step(1'b0, 1'b0, '0);
        chk("redir_stall_fi_iaddr", 32'(fi_iaddr), 32'h40);
        chk("redir_stall_fi_v2", 32'(fi_valid), 32'h1);

        // Wrap at the top of the address space.
        step(1'b0, 1'b1, 30'h3FFF_FFFF);
        chk("wrap_iaddr_max", 32'(IADDR), 32'h3FFF_FFFF);
        step(1'b0, 1'b0, '0);
        chk("wrap_iaddr_zero", 32'(IADDR), 32'h0);
        chk("wrap_fi_iaddr", 32'(fi_iaddr), 32'h3FFF_FFFF);
        chk("wrap_fi_link", fi_link, 32'h0);
        step(1'b0, 1'b0, '0);
        chk("wrap_next_fi_iaddr", 32'(fi_iaddr), 32'h0);
        chk("wrap_next_fi_link", fi_link, 32'h4);

        // Mid-operation reset with a valid instruction at PC=0x20.
        step(1'b0, 1'b1, 30'h1F);
        step(1'b0, 1'b0, '0);
        chk("pre_rst_fi_valid", 32'(fi_valid), 32'h1);
        chk("pre_rst_iaddr", 32'(IADDR), 32'h20);
        reset_pulse(1'b0, 1'b0, '0);
        chk("post_rst_ireq", 32'(IREQ), 32'h1);
        chk("post_rst_iaddr", 32'(IADDR), 32'h0);
        chk("post_rst_fi_valid", 32'(fi_valid), 32'h0);
        step(1'b0, 1'b0, '0);
        chk("post_rst_first_valid", 32'(fi_valid), 32'h1);
        chk("post_rst_first_iaddr", 32'(fi_iaddr), 32'h0);

        // Random traffic with a scrambling memory.
        mem_mode = 1'b1;
        repeat (400) begin
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 3))
                0:       addr = 30'h3FFF_FFF0 + 30'($urandom_range(0, 15));
                1:       addr = 30'($urandom_range(0, 63));
                default: addr = 30'($urandom);
            endcase
            if (r < 2) begin
                reset_pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr);
            end else begin
                step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), addr);
            end
        end

        @(posedge CLK);
        #3;
        chk("sb_drain", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
